// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_ctrl
// Description : Instruction-fetch controller with a one-entry output buffer,
//               redirect handling and a memory-busy timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned BUSY_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        im_busy,
  input  logic [31:0] im_instr,
  output logic [31:0] im_pc,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        addr_err,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  localparam logic [7:0] BUSY_LIMIT_C = 8'(BUSY_LIMIT);

  state_t      state_q,     state_d;
  logic [31:0] im_pc_q,     im_pc_d;
  logic        valid_q,     valid_d;
  logic [31:0] out_q,       out_d;
  logic [31:0] ipc_q,       ipc_d;
  logic [7:0]  busy_cnt_q,  busy_cnt_d;
  logic        addr_err_q,  addr_err_d;
  logic        timeout_q,   timeout_d;

  always_comb begin
    state_d    = state_q;
    im_pc_d    = im_pc_q;
    valid_d    = valid_q;
    out_d      = out_q;
    ipc_d      = ipc_q;
    busy_cnt_d = busy_cnt_q;
    addr_err_d = 1'b0;

    if (redirect_valid) begin
      // Redirect overrides everything, including a capture in this cycle
      im_pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d    = 1'b0;
      state_d    = ST_FETCH;
      busy_cnt_d = 8'd0;
      addr_err_d = |redirect_pc[1:0];
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (busy_cnt_q == BUSY_LIMIT_C) begin
            state_d    = ST_ERR;
            valid_d    = 1'b0;
            busy_cnt_d = 8'd0;
          end else if (!im_busy) begin
            busy_cnt_d = 8'd0;
            if (!valid_q || !stall_in) begin
              out_d   = im_instr;
              ipc_d   = im_pc_q;
              valid_d = 1'b1;
              im_pc_d = im_pc_q + 32'd4;
            end else begin
              state_d = ST_HOLD;
            end
          end else begin
            busy_cnt_d = busy_cnt_q + 8'd1;
            if (valid_q && !stall_in) begin
              valid_d = 1'b0;
            end
          end
        end
        ST_HOLD: begin
          busy_cnt_d = 8'd0;
          if (!stall_in) begin
            valid_d = 1'b0;
            state_d = ST_FETCH;
          end
        end
        ST_ERR: begin
          busy_cnt_d = 8'd0;
          valid_d    = 1'b0;
        end
        default: begin
          state_d    = ST_FETCH;
          busy_cnt_d = 8'd0;
          valid_d    = 1'b0;
        end
      endcase
    end

    timeout_d = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      im_pc_q    <= RESET_PC;
      valid_q    <= 1'b0;
      out_q      <= 32'd0;
      ipc_q      <= 32'd0;
      busy_cnt_q <= 8'd0;
      addr_err_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      im_pc_q    <= im_pc_d;
      valid_q    <= valid_d;
      out_q      <= out_d;
      ipc_q      <= ipc_d;
      busy_cnt_q <= busy_cnt_d;
      addr_err_q <= addr_err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign im_pc       = im_pc_q;
  assign instr_valid = valid_q;
  assign instr_out   = out_q;
  assign instr_pc    = ipc_q;
  assign addr_err    = addr_err_q;
  assign timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_ctrl
// Description : Vector-table and scoreboard bench for if_fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        im_busy;
  logic [31:0] im_instr;
  logic [31:0] im_pc;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        addr_err;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] out;
    logic [31:0] ipc;
    logic        aerr;
    logic        tmo;
  } exp_t;

  typedef struct {
    logic        busy;
    logic [31:0] instr;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[20];

  if_fetch_ctrl #(
    .RESET_PC  (32'h0000_3000),
    .BUSY_LIMIT(15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .im_busy       (im_busy),
    .im_instr      (im_instr),
    .im_pc         (im_pc),
    .stall_in      (stall_in),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .addr_err      (addr_err),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic busy, logic [31:0] instr, logic stall, logic rv,
                              logic [31:0] rpc, logic [31:0] pc, logic valid,
                              logic [31:0] out, logic [31:0] ipc, logic aerr, logic tmo);
    vec_t v;
    v.busy = busy; v.instr = instr; v.stall = stall; v.rv = rv; v.rpc = rpc;
    v.e.pc = pc; v.e.valid = valid; v.e.out = out; v.e.ipc = ipc;
    v.e.aerr = aerr; v.e.tmo = tmo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, " im_pc"},       im_pc,              e.pc);
    chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, e.valid});
    chk({tag, " instr_out"},   instr_out,          e.out);
    chk({tag, " instr_pc"},    instr_pc,           e.ipc);
    chk({tag, " addr_err"},    {31'd0, addr_err},  {31'd0, e.aerr});
    chk({tag, " timeout"},     {31'd0, timeout},   {31'd0, e.tmo});
  endtask

  // Called at a negedge; drives one cycle, compares after the edge, returns at the next negedge.
  task automatic apply(input string tag, input vec_t v);
    exp_t e;
    im_busy        = v.busy;
    im_instr       = v.instr;
    stall_in       = v.stall;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    exp_q.push_back(v.e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_outputs(tag, e);
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t rst_e;
    rst_e.pc = 32'h3000; rst_e.valid = 1'b0; rst_e.out = 32'd0;
    rst_e.ipc = 32'd0; rst_e.aerr = 1'b0; rst_e.tmo = 1'b0;

    //                busy instr          stl rv rpc            im_pc         v  out            ipc           ae to
    vecs[0]  = mk(1, 32'h0,         0, 0, 32'h0,        32'h3000,     0, 32'h0,        32'h0,        0, 0);
    vecs[1]  = mk(0, 32'h1111_1111, 0, 0, 32'h0,        32'h3004,     1, 32'h1111_1111, 32'h3000,     0, 0);
    vecs[2]  = mk(1, 32'h0,         0, 0, 32'h0,        32'h3004,     0, 32'h1111_1111, 32'h3000,     0, 0);
    vecs[3]  = mk(0, 32'h2408_0001, 0, 0, 32'h0,        32'h3008,     1, 32'h2408_0001, 32'h3004,     0, 0);
    vecs[4]  = mk(0, 32'hDEAD_BEEF, 1, 0, 32'h0,        32'h3008,     1, 32'h2408_0001, 32'h3004,     0, 0);
    vecs[5]  = mk(0, 32'hDEAD_BEEF, 1, 0, 32'h0,        32'h3008,     1, 32'h2408_0001, 32'h3004,     0, 0);
    vecs[6]  = mk(0, 32'hDEAD_BEEF, 1, 0, 32'h0,        32'h3008,     1, 32'h2408_0001, 32'h3004,     0, 0);
    vecs[7]  = mk(0, 32'hDEAD_BEEF, 0, 0, 32'h0,        32'h3008,     0, 32'h2408_0001, 32'h3004,     0, 0);
    vecs[8]  = mk(0, 32'h3333_3333, 0, 0, 32'h0,        32'h300C,     1, 32'h3333_3333, 32'h3008,     0, 0);
    vecs[9]  = mk(0, 32'h4444_4444, 0, 1, 32'h4002,     32'h4000,     0, 32'h3333_3333, 32'h3008,     1, 0);
    vecs[10] = mk(1, 32'h0,         0, 0, 32'h0,        32'h4000,     0, 32'h3333_3333, 32'h3008,     0, 0);
    vecs[11] = mk(0, 32'h5555_5555, 0, 0, 32'h0,        32'h4004,     1, 32'h5555_5555, 32'h4000,     0, 0);
    vecs[12] = mk(1, 32'h0,         0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h5555_5555, 32'h4000,     0, 0);
    vecs[13] = mk(0, 32'h6666_6666, 0, 0, 32'h0,        32'h0,        1, 32'h6666_6666, 32'hFFFF_FFFC, 0, 0);
    vecs[14] = mk(0, 32'hABCD_0000, 0, 1, 32'h3000,     32'h3000,     0, 32'h6666_6666, 32'hFFFF_FFFC, 0, 0);
    vecs[15] = mk(0, 32'h7777_7777, 0, 0, 32'h0,        32'h3004,     1, 32'h7777_7777, 32'h3000,     0, 0);
    vecs[16] = mk(1, 32'h0,         0, 0, 32'h0,        32'h3004,     0, 32'h7777_7777, 32'h3000,     0, 0);
    vecs[17] = mk(0, 32'h8888_8888, 0, 0, 32'h0,        32'h3008,     1, 32'h8888_8888, 32'h3004,     0, 0);
    vecs[18] = mk(1, 32'h0,         1, 0, 32'h0,        32'h3008,     1, 32'h8888_8888, 32'h3004,     0, 0);
    vecs[19] = mk(0, 32'h9999_9999, 0, 0, 32'h0,        32'h300C,     1, 32'h9999_9999, 32'h3008,     0, 0);

    reset = 1'b1; im_busy = 1'b0; im_instr = 32'd0; stall_in = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    #2;
    check_outputs("reset", rst_e);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Busy timeout: counter reaches 15 after 15 busy cycles, ERR on the 16th edge
    for (int k = 1; k <= 16; k++) begin
      apply($sformatf("busy%0d", k),
            mk(1, 32'h0, 0, 0, 32'h0, 32'h300C, 0, 32'h9999_9999, 32'h3008, 0, (k == 16)));
    end
    for (int k = 0; k < 3; k++) begin
      apply($sformatf("err%0d", k),
            mk(0, 32'hCAFE_0000, 0, 0, 32'h0, 32'h300C, 0, 32'h9999_9999, 32'h3008, 0, 1));
    end
    apply("err_redirect", mk(1, 32'h0, 0, 1, 32'h5000, 32'h5000, 0, 32'h9999_9999, 32'h3008, 0, 0));
    apply("fetch5000",    mk(0, 32'hAAAA_AAAA, 0, 0, 32'h0, 32'h5004, 1, 32'hAAAA_AAAA, 32'h5000, 0, 0));
    apply("to_hold",      mk(0, 32'hBAD0_0000, 1, 0, 32'h0, 32'h5004, 1, 32'hAAAA_AAAA, 32'h5000, 0, 0));
    apply("hold",         mk(0, 32'hBAD0_0001, 1, 0, 32'h0, 32'h5004, 1, 32'hAAAA_AAAA, 32'h5000, 0, 0));

    // Asynchronous reset in HOLD, observed before any clock edge
    #2;
    reset = 1'b1;
    #1;
    check_outputs("async_reset", rst_e);
    @(negedge clk);
    reset = 1'b0;
    apply("post_reset", mk(0, 32'hBBBB_BBBB, 0, 0, 32'h0, 32'h3004, 1, 32'hBBBB_BBBB, 32'h3000, 0, 0));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter BUSY_LIMIT, default 15, consecutive im_busy-high cycles that trigger a timeout; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 im_busy  input  1  instruction memory busy; high means im_instr is not valid for the current im_pc.
REQ-006 im_instr  input  32  instruction word from memory for im_pc.
REQ-007 im_pc  output  32  fetch address to instruction memory; registered.
REQ-008 stall_in  input  1  downstream (IF/ID) not ready; ready = !stall_in.
REQ-009 redirect_valid  input  1  branch/jump redirect request, single-cycle.
REQ-010 redirect_pc  input  32  redirect target address.
REQ-011 instr_valid  output  1  instr_out/instr_pc hold a fetched instruction.
REQ-012 instr_out  output  32  buffered instruction.
REQ-013 instr_pc  output  32  address of instr_out.
REQ-014 addr_err  output  1  one-cycle pulse: redirect_pc[1:0] was nonzero.
REQ-015 timeout  output  1  high while the FSM is in ERR.

Function
REQ-016 The FSM SHALL have three states: FETCH, HOLD and ERR, encoded in registers.
REQ-017 The block SHALL treat im_instr as valid only in a cycle where im_busy=0.
REQ-018 im_pc SHALL change only on the FETCH capture, a redirect, or reset, so that it is stable while im_busy=1.
REQ-019 FETCH capture: im_busy=0 and (instr_valid=0 or stall_in=0).
- Effect: instr_out<=im_instr, instr_pc<=im_pc, instr_valid<=1, im_pc<=im_pc+4.
- FSM stays in FETCH.
REQ-020 FETCH, im_busy=0, instr_valid=1, stall_in=1: the FSM SHALL go to HOLD, with the buffer and im_pc unchanged.
REQ-021 HOLD, stall_in=0: the buffer SHALL be consumed (instr_valid<=0) and the FSM SHALL return to FETCH; no capture occurs in that cycle.
REQ-022 Consume in FETCH without capture (instr_valid=1, stall_in=0, im_busy=1): instr_valid<=0.
REQ-023 im_pc+4 SHALL be 32-bit modulo arithmetic; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
REQ-024 Busy counter (8-bit):
- increments each cycle the FSM is in FETCH with im_busy=1;
- clears when im_busy=0, on a redirect, or on leaving FETCH.
REQ-025 When the busy counter reaches BUSY_LIMIT, the FSM SHALL enter ERR on the next edge and clear instr_valid.
REQ-026 ERR SHALL stop all captures and hold im_pc; only a redirect or reset leaves ERR.
REQ-027 Redirect has highest priority in every state:
- im_pc<={redirect_pc[31:2],2'b00};
- instr_valid<=0;
- FSM<=FETCH;
- busy counter<=0;
- any capture in that cycle is discarded.
REQ-028 A redirect with redirect_pc[1:0]!=0 SHALL pulse addr_err for exactly the next cycle; otherwise addr_err=0.
REQ-029 Redirect and consume in the same cycle: the redirect wins and the buffered instruction is dropped; the downstream sampled it on that same edge because stall_in=0.
REQ-030 instr_out and instr_pc SHALL hold their value whenever no capture occurs.

Reset
REQ-031 On reset assertion, outputs SHALL take these values immediately, independent of clk:
- im_pc=RESET_PC, FSM=FETCH;
- instr_valid=0, instr_out=0, instr_pc=0;
- addr_err=0, timeout=0, busy counter=0.
REQ-032 Reset asserted mid-operation (HOLD or ERR) SHALL discard the buffer and the error state; fetching resumes at RESET_PC on the first edge after deassertion.

Verification
REQ-033 Reset release, memory returns busy=1 for 1 cycle after each im_pc change, stall_in=0 -> im_pc sequence 3000,3004,3008; instr_pc follows one capture behind; instr_valid=1 every other cycle.
REQ-034 Buffer holds 0x24080001 at 0x3004, stall_in=1 for 3 cycles -> state HOLD; im_pc stays 0x3008; instr_out unchanged; one cycle after stall_in=0, instr_valid=0.
REQ-035 redirect_valid=1, redirect_pc=0x0000_4002, in the same cycle as a capture -> im_pc=0x4000, instr_valid=0 next cycle, addr_err=1 for exactly one cycle.
REQ-036 im_busy held at 1 for BUSY_LIMIT=15 cycles -> timeout=1, im_pc frozen; a redirect to 0x5000 -> timeout=0 and fetching at 0x5000.
REQ-037 redirect_pc=0xFFFF_FFFC, im_busy=0 -> next im_pc=0x0000_0000, instr_pc=0xFFFF_FFFC.
REQ-038 Reset asserted asynchronously while in HOLD -> instr_valid=0 and im_pc=0x3000 before the next clk edge.
